// File: rtl/can_lite_axi_access_arbiter_if.sv
// Bus bundle for the CAN-lite AXI access arbiter: requester side plus the
// AXI4-Lite master side. master = arbiter view, slave = environment view.
interface can_lite_axi_access_arbiter_if #(
  parameter int NUM_REQ   = 3,
  parameter int OFS_WIDTH = 10
);
  logic [NUM_REQ-1:0]           REQ_VALID;
  logic [NUM_REQ-1:0]           REQ_WE;
  logic [NUM_REQ*OFS_WIDTH-1:0] REQ_OFS;
  logic [NUM_REQ*32-1:0]        REQ_WDATA;
  logic [NUM_REQ-1:0]           REQ_DONE;
  logic [31:0]                  RSP_RDATA;
  logic                         RSP_ERR;

  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_OFS, REQ_WDATA,
    output REQ_DONE, RSP_RDATA, RSP_ERR,
    output M_AXI_AWADDR, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_OFS, REQ_WDATA,
    input  REQ_DONE, RSP_RDATA, RSP_ERR,
    input  M_AXI_AWADDR, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/can_lite_axi_access_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave among NUM_REQ requesters.
// Ports: S_AXI_ACLK, S_AXI_ARESET (async, active-high), bus (master modport).
module can_lite_axi_access_arbiter #(
  parameter int          NUM_REQ            = 3,
  parameter int          OFS_WIDTH          = 10,
  parameter logic [31:0] C_BASEADDR         = 32'h7240_0000,
  parameter int          C_S_AXI_DATA_WIDTH = 32
) (
  input logic S_AXI_ACLK,
  input logic S_AXI_ARESET,
  can_lite_axi_access_arbiter_if.master bus
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD, RD_DATA
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [IW-1:0]       last_q, last_d;
  logic [DW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                aw_ok_q, aw_ok_d;
  logic                w_ok_q, w_ok_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;

  logic [OFS_WIDTH-1:0] ofs_a [NUM_REQ];
  logic [DW-1:0]        wd_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ofs_a[g] = bus.REQ_OFS[g*OFS_WIDTH +: OFS_WIDTH];
    assign wd_a[g]  = bus.REQ_WDATA[g*DW +: DW];
  end

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] jj;

  // First active requester strictly after the last grant, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    jj    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      jj = IW'((int'(last_q) + k) % NUM_REQ);
      if (!found && bus.REQ_VALID[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    aw_ok_d = aw_ok_q;
    w_ok_d  = w_ok_q;
    done_d  = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The DONE cycle is still IDLE; the requester may still show
        // VALID there, so grants wait one cycle.
        if (found && done_q == '0) begin
          grant_d = pick;
          last_d  = pick;
          addr_d  = C_BASEADDR |
                    {{(DW-OFS_WIDTH){1'b0}}, ofs_a[pick]};
          wdata_d = wd_a[pick];
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          state_d = bus.REQ_WE[pick] ? WR : RD;
        end
      end
      WR: begin
        aw_ok_d = aw_ok_q | bus.M_AXI_AWREADY;
        w_ok_d  = w_ok_q | bus.M_AXI_WREADY;
        if (aw_ok_d && w_ok_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bus.M_AXI_BVALID) begin
          done_d[grant_q] = 1'b1;
          err_d   = bus.M_AXI_BRESP != 2'b00;
          state_d = IDLE;
        end
      end
      RD: begin
        if (bus.M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus.M_AXI_RVALID) begin
          rdata_d = bus.M_AXI_RDATA;
          done_d[grant_q] = 1'b1;
          err_d   = bus.M_AXI_RRESP != 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      aw_ok_q <= 1'b0;
      w_ok_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      aw_ok_q <= aw_ok_d;
      w_ok_q  <= w_ok_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = 4'hF;
  assign bus.M_AXI_AWVALID = (state_q == WR) && !aw_ok_q;
  assign bus.M_AXI_WVALID  = (state_q == WR) && !w_ok_q;
  assign bus.M_AXI_BREADY  = (state_q == WR_RESP);
  assign bus.M_AXI_ARVALID = (state_q == RD);
  assign bus.M_AXI_RREADY  = (state_q == RD_DATA);
  assign bus.REQ_DONE      = done_q;
  assign bus.RSP_RDATA     = rdata_q;
  assign bus.RSP_ERR       = err_q;
endmodule

// File: tb/tb_can_lite_axi_access_arbiter.sv
// Bench for can_lite_axi_access_arbiter: vector table, corner sequences
// and a randomized run against a queue-based round-robin model.
module tb_can_lite_axi_access_arbiter;
  localparam int N  = 3;
  localparam int OW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_lite_axi_access_arbiter_if #(.NUM_REQ(N), .OFS_WIDTH(OW)) bus ();

  can_lite_axi_access_arbiter #(
    .NUM_REQ(N), .OFS_WIDTH(OW),
    .C_BASEADDR(32'h7240_0000), .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- AXI slave model ----------------
  bit          rand_mode = 0;
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp = 0, r_resp = 0;
  logic [31:0] r_data = 0;
  int          awc = 0, wc = 0, bc = 0, arc = 0, rc = 0;
  int          aw_cyc = 0, w_cyc = 0, b_hs = 0, r_hs = 0;
  logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;
  logic [3:0]  s_wstrb = 0;
  bit          last_kind = 0;
  logic [1:0]  last_resp = 0;
  logic [31:0] last_rdata = 0;

  initial begin
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0;
    bus.M_AXI_BVALID = 0;  bus.M_AXI_BRESP = 0;
    bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
    bus.M_AXI_RDATA = 0;   bus.M_AXI_RRESP = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0;
        bus.M_AXI_BVALID = 0;  bus.M_AXI_ARREADY = 0;
        bus.M_AXI_RVALID = 0;
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
      end else begin
        if (bus.M_AXI_AWVALID) begin
          aw_cyc++;
          if (awc >= aw_dly) begin
            bus.M_AXI_AWREADY = 1; s_awaddr = bus.M_AXI_AWADDR;
          end else begin
            bus.M_AXI_AWREADY = 0; awc++;
          end
        end else begin
          bus.M_AXI_AWREADY = 0; awc = 0;
          if (rand_mode) aw_dly = $urandom_range(0, 2);
        end
        if (bus.M_AXI_WVALID) begin
          w_cyc++;
          if (wc >= w_dly) begin
            bus.M_AXI_WREADY = 1;
            s_wdata = bus.M_AXI_WDATA; s_wstrb = bus.M_AXI_WSTRB;
          end else begin
            bus.M_AXI_WREADY = 0; wc++;
          end
        end else begin
          bus.M_AXI_WREADY = 0; wc = 0;
          if (rand_mode) w_dly = $urandom_range(0, 2);
        end
        if (bus.M_AXI_BREADY) begin
          if (bc >= b_dly) begin
            bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = b_resp;
            b_hs++; last_kind = 1; last_resp = b_resp;
          end else begin
            bus.M_AXI_BVALID = 0; bc++;
          end
        end else begin
          bus.M_AXI_BVALID = 0; bc = 0;
          if (rand_mode) begin
            b_dly = $urandom_range(0, 2);
            b_resp = 2'($urandom_range(0, 3));
          end
        end
        if (bus.M_AXI_ARVALID) begin
          if (arc >= ar_dly) begin
            bus.M_AXI_ARREADY = 1; s_araddr = bus.M_AXI_ARADDR;
          end else begin
            bus.M_AXI_ARREADY = 0; arc++;
          end
        end else begin
          bus.M_AXI_ARREADY = 0; arc = 0;
          if (rand_mode) ar_dly = $urandom_range(0, 2);
        end
        if (bus.M_AXI_RREADY) begin
          if (rc >= r_dly) begin
            bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = r_data;
            bus.M_AXI_RRESP = r_resp;
            r_hs++; last_kind = 0; last_resp = r_resp;
            last_rdata = r_data;
          end else begin
            bus.M_AXI_RVALID = 0; rc++;
          end
        end else begin
          bus.M_AXI_RVALID = 0; rc = 0;
          if (rand_mode) begin
            r_dly = $urandom_range(0, 2);
            r_resp = 2'($urandom_range(0, 3));
            r_data = $urandom;
          end
        end
      end
    end
  end

  // ---------------- DONE monitor ----------------
  int          done_evt = 0;
  int          mon_idx = -1;
  logic [31:0] mon_rdata = 0;
  logic        mon_err = 0;

  initial forever begin
    @(negedge clk);
    if (!rst && bus.REQ_DONE != '0) begin
      chk("done_onehot", 32'($countones(bus.REQ_DONE)), 1);
      for (int i = 0; i < N; i++)
        if (bus.REQ_DONE[i]) mon_idx = i;
      mon_rdata = bus.RSP_RDATA;
      mon_err = bus.RSP_ERR;
      done_evt++;
    end
  end

  task automatic wait_done(input string name, input int budget,
                           output int idx, output int lat);
    int start;
    start = done_evt;
    lat = 0;
    while (done_evt == start && lat < budget) begin
      tick();
      lat++;
    end
    if (done_evt == start) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no REQ_DONE within %0d cycles", name, budget);
      idx = -1;
    end else begin
      idx = mon_idx;
    end
  endtask

  task automatic drive(input int i, input bit we,
                       input logic [9:0] ofs, input logic [31:0] wd);
    bus.REQ_WE[i] = we;
    bus.REQ_OFS[i*OW +: OW] = ofs;
    bus.REQ_WDATA[i*32 +: 32] = wd;
    bus.REQ_VALID[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          req;
    bit          we;
    logic [9:0]  ofs;
    logic [31:0] wdata;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_aw, e_w, e_lat;
  } vec_t;

  vec_t tbl [6];

  // Random-phase model state
  int          rr_q [$];
  bit          m_we  [N];
  logic [9:0]  m_ofs [N];
  logic [31:0] m_wd  [N];

  task automatic new_txn(input int i);
    m_we[i]  = 1'($urandom_range(0, 1));
    m_ofs[i] = 10'($urandom);
    m_wd[i]  = $urandom;
    drive(i, m_we[i], m_ofs[i], m_wd[i]);
  endtask

  initial begin
    vec_t v;
    int idx, lat, ev0, exp_idx, pos;
    logic [N-1:0] mask;
    logic [31:0] m_rdata;

    tbl[0] = '{0, 1, 10'h010, 32'hA5A5_0001, 0, 0, 0, 0, 0, 2'b00,
               32'h0, 32'h7240_0010, 1'b0, 32'h0, 1, 1, 3};
    tbl[1] = '{2, 0, 10'h3FC, 32'h0, 0, 0, 0, 0, 4, 2'b10,
               32'hDEAD_BEEF, 32'h7240_03FC, 1'b1, 32'hDEAD_BEEF, 0, 0, 7};
    tbl[2] = '{1, 1, 10'h004, 32'h1111_2222, 3, 0, 0, 0, 0, 2'b00,
               32'h0, 32'h7240_0004, 1'b0, 32'hDEAD_BEEF, 4, 1, 6};
    tbl[3] = '{0, 1, 10'h008, 32'h3333_4444, 0, 3, 0, 0, 0, 2'b11,
               32'h0, 32'h7240_0008, 1'b1, 32'hDEAD_BEEF, 1, 4, 6};
    tbl[4] = '{1, 0, 10'h000, 32'h0, 0, 0, 0, 2, 0, 2'b00,
               32'h1234_5678, 32'h7240_0000, 1'b0, 32'h1234_5678, 0, 0, 5};
    tbl[5] = '{2, 1, 10'h3FF, 32'hFFFF_FFFF, 1, 1, 2, 0, 0, 2'b01,
               32'h0, 32'h7240_03FF, 1'b1, 32'h1234_5678, 2, 2, 6};

    bus.REQ_VALID = '0; bus.REQ_WE = '0;
    bus.REQ_OFS = '0;   bus.REQ_WDATA = '0;

    // Reset state
    tick(); tick();
    chk("rst_awvalid", 32'(bus.M_AXI_AWVALID), 0);
    chk("rst_wvalid",  32'(bus.M_AXI_WVALID), 0);
    chk("rst_arvalid", 32'(bus.M_AXI_ARVALID), 0);
    chk("rst_bready",  32'(bus.M_AXI_BREADY), 0);
    chk("rst_rready",  32'(bus.M_AXI_RREADY), 0);
    chk("rst_done",    32'(bus.REQ_DONE), 0);
    chk("rst_err",     32'(bus.RSP_ERR), 0);
    chk("rst_rdata",   bus.RSP_RDATA, 0);
    chk("rst_awaddr",  bus.M_AXI_AWADDR, 0);
    chk("rst_wdata",   bus.M_AXI_WDATA, 0);
    rst = 1'b0;
    tick(); tick();

    // Table-driven single transactions
    for (int t = 0; t < 6; t++) begin
      v = tbl[t];
      aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d;
      ar_dly = v.ar_d; r_dly = v.r_d;
      b_resp = v.resp; r_resp = v.resp; r_data = v.rdata;
      aw_cyc = 0; w_cyc = 0; b_hs = 0; r_hs = 0;
      ev0 = done_evt;
      drive(v.req, v.we, v.ofs, v.wdata);
      wait_done($sformatf("t%0d_wait", t), 40, idx, lat);
      bus.REQ_VALID = '0;
      chk($sformatf("t%0d_idx", t), 32'(idx), 32'(v.req));
      chk($sformatf("t%0d_err", t), 32'(mon_err), 32'(v.e_err));
      chk($sformatf("t%0d_rdata", t), mon_rdata, v.e_rdata);
      chk($sformatf("t%0d_lat", t), 32'(lat), 32'(v.e_lat));
      chk($sformatf("t%0d_awcyc", t), 32'(aw_cyc), 32'(v.e_aw));
      chk($sformatf("t%0d_wcyc", t), 32'(w_cyc), 32'(v.e_w));
      if (v.we) begin
        chk($sformatf("t%0d_awaddr", t), s_awaddr, v.e_addr);
        chk($sformatf("t%0d_wdata", t), s_wdata, v.wdata);
        chk($sformatf("t%0d_wstrb", t), 32'(s_wstrb), 32'hF);
        chk($sformatf("t%0d_bhs", t), 32'(b_hs), 1);
      end else begin
        chk($sformatf("t%0d_araddr", t), s_araddr, v.e_addr);
        chk($sformatf("t%0d_rhs", t), 32'(r_hs), 1);
      end
      tick(); tick(); tick();
      chk($sformatf("t%0d_once", t), 32'(done_evt - ev0), 1);
    end

    // Requester drops VALID mid-transaction: DONE still comes, once
    aw_dly = 2; w_dly = 0; b_dly = 0; b_resp = 0;
    ev0 = done_evt;
    drive(0, 1, 10'h020, 32'h5555_AAAA);
    tick(); tick();
    bus.REQ_VALID = '0;
    wait_done("drop_wait", 40, idx, lat);
    chk("drop_idx", 32'(idx), 0);
    tick(); tick(); tick(); tick();
    chk("drop_once", 32'(done_evt - ev0), 1);

    // Fairness: all requesters held for 9 transactions after reset
    do_reset();
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
    for (int i = 0; i < N; i++)
      drive(i, 1'(i % 2), 10'(4 * i), 32'(i));
    for (int k = 0; k < 9; k++) begin
      wait_done($sformatf("rr%0d_wait", k), 40, idx, lat);
      chk($sformatf("rr%0d_idx", k), 32'(idx), 32'(k % N));
    end
    bus.REQ_VALID = '0;
    tick(); tick();

    // Reset during RD_DATA
    r_dly = 20; r_resp = 0; r_data = 32'hCAFE_0001;
    drive(1, 0, 10'h100, 32'h0);
    lat = 0;
    while (!bus.M_AXI_RREADY && lat < 20) begin
      tick(); lat++;
    end
    chk("rdd_reached", 32'(bus.M_AXI_RREADY), 1);
    rst = 1'b1;
    #1;
    chk("rdd_arvalid", 32'(bus.M_AXI_ARVALID), 0);
    chk("rdd_rready", 32'(bus.M_AXI_RREADY), 0);
    chk("rdd_done", 32'(bus.REQ_DONE), 0);
    tick(); tick();
    r_dly = 0;
    rst = 1'b0;
    wait_done("rdd_wait", 40, idx, lat);
    bus.REQ_VALID = '0;
    chk("rdd_idx", 32'(idx), 1);
    chk("rdd_lat", 32'(lat), 3);
    chk("rdd_rdata", mon_rdata, 32'hCAFE_0001);
    chk("rdd_araddr", s_araddr, 32'h7240_0100);
    tick(); tick();

    // Randomized phases against the rotating priority queue model
    do_reset();
    rand_mode = 1;
    m_rdata = 0;
    rr_q = {};
    for (int i = 0; i < N; i++) rr_q.push_back(i);
    for (int ph = 0; ph < 5; ph++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (mask[i]) new_txn(i);
      for (int k = 0; k < 6; k++) begin
        exp_idx = -1; pos = 0;
        for (int p = 0; p < N; p++)
          if (exp_idx < 0 && mask[rr_q[p]]) begin
            exp_idx = rr_q[p]; pos = p;
          end
        for (int p = 0; p <= pos; p++)
          rr_q.push_back(rr_q.pop_front());
        wait_done($sformatf("rnd%0d_%0d_wait", ph, k), 60, idx, lat);
        if (idx < 0) break;
        chk($sformatf("rnd%0d_%0d_idx", ph, k), 32'(idx), 32'(exp_idx));
        chk($sformatf("rnd%0d_%0d_kind", ph, k),
            32'(last_kind), 32'(m_we[exp_idx]));
        chk($sformatf("rnd%0d_%0d_err", ph, k),
            32'(mon_err), 32'(last_resp != 2'b00));
        if (m_we[exp_idx]) begin
          chk($sformatf("rnd%0d_%0d_awaddr", ph, k), s_awaddr,
              32'h7240_0000 | 32'(m_ofs[exp_idx]));
          chk($sformatf("rnd%0d_%0d_wdata", ph, k), s_wdata,
              m_wd[exp_idx]);
        end else begin
          m_rdata = last_rdata;
          chk($sformatf("rnd%0d_%0d_araddr", ph, k), s_araddr,
              32'h7240_0000 | 32'(m_ofs[exp_idx]));
        end
        chk($sformatf("rnd%0d_%0d_rdata", ph, k), mon_rdata, m_rdata);
        if (k == 5) bus.REQ_VALID = '0;
        else new_txn(exp_idx);
      end
      bus.REQ_VALID = '0;
      tick(); tick(); tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/can_lite_axi_access_arbiter.md
Name: can_lite_axi_access_arbiter

Overview:
- Shares the CAN-lite controller's AXI4-Lite slave port among NUM_REQ local requesters, e.g. a CAN TX scheduler, an RX drain engine and a debug port.
- Each requester issues single-word register reads or writes over a simple valid/done interface.
- The block grants requesters round-robin, runs one AXI4-Lite transaction at a time and returns the response to the granted requester.
- It sits between the local requesters and the CAN-lite controller's S_AXI_* port.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- OFS_WIDTH, 10, register offset width; covers the 0x3FF decode window.
- C_BASEADDR, 32'h72400000, OR'd with the offset to form the AXI address.
- C_S_AXI_DATA_WIDTH, 32, data width. Fixed at 32.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESET  in  1  reset, asynchronous, active-high.
- REQ_VALID  in  NUM_REQ  per-requester request, held until DONE.
- REQ_WE  in  NUM_REQ  1=write, 0=read.
- REQ_OFS  in  NUM_REQ*OFS_WIDTH  packed byte offsets; requester i at [i*OFS_WIDTH +: OFS_WIDTH].
- REQ_WDATA  in  NUM_REQ*32  packed write data.
- REQ_DONE  out  NUM_REQ  one-cycle completion pulse, one-hot.
- RSP_RDATA  out  32  read data; valid in the REQ_DONE cycle.
- RSP_ERR  out  1  1 if BRESP/RRESP != OKAY; valid in the REQ_DONE cycle.
- M_AXI_AWADDR  out  32  write address.
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  32
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset (async, immediate, also mid-transaction):
  - FSM goes to IDLE.
  - All *VALID, BREADY, RREADY, REQ_DONE and RSP_ERR are 0. RSP_RDATA is 0. Address/data registers are 0.
  - The round-robin pointer is set so that requester 0 has highest priority on the first grant.
- FSM states: IDLE, WR, WR_RESP, RD, RD_DATA.
- IDLE:
  - If any REQ_VALID is set, grant the first set bit searching upward from (last_grant+1) mod NUM_REQ, with wrap-around.
  - On grant, latch the index, WE, address (C_BASEADDR | zero-extended offset) and WDATA.
  - Go to WR (WE=1) or RD (WE=0). Outputs assert on the next cycle.
- WR:
  - AWVALID and WVALID assert together; each drops independently on its own READY handshake.
  - Once both handshakes have occurred, in either order or the same cycle, go to WR_RESP.
  - Address and data stay stable while valid.
- WR_RESP:
  - BREADY=1.
  - On BVALID: pulse REQ_DONE[grant] with RSP_ERR = (BRESP != 0) and RSP_RDATA unchanged, then return to IDLE.
- RD:
  - ARVALID=1 until ARREADY, then go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID: register RDATA to RSP_RDATA, pulse REQ_DONE[grant] with RSP_ERR = (RRESP != 0), then return to IDLE.
- Latency: minimum from grant to REQ_DONE is 3 cycles, with zero-wait slave. REQ_DONE is registered.
- Arbitration:
  - At most one transaction is outstanding; there is no pipelining of reads and writes.
  - A new grant is evaluated only in IDLE, i.e. the cycle after REQ_DONE. Minimum spacing between transactions is therefore 1 idle cycle.
  - last_grant updates at grant.
  - A requester deasserting REQ_VALID before DONE is a protocol error. The latched transaction still completes and DONE still pulses.
  - A requester may reassert in the cycle after its DONE. It then has lowest priority among active requesters.
- Fairness: with all requesters active, grants rotate 0,1,...,NUM_REQ-1,0.
- No timeout. A hung slave stalls the block until reset.

Test Plan:
- Single write, req0, ofs 0x010, data 0xA5A5_0001, zero-wait slave -> AWADDR=0x7240_0010, WDATA=0xA5A5_0001, WSTRB=4'hF; REQ_DONE[0] pulses exactly once; RSP_ERR=0.
- Read, req2, ofs 0x3FC, slave returns 0xDEAD_BEEF after 4 wait cycles with RRESP=2'b10 -> ARADDR=0x7240_03FC; DONE[2] pulses; RSP_RDATA=0xDEAD_BEEF; RSP_ERR=1.
- All three requesters held valid for 9 transactions -> grant order 0,1,2,0,1,2,0,1,2; never two DONE bits in one cycle.
- AWREADY delayed 3 cycles, WREADY given first cycle (and the reverse case) -> WVALID drops after 1 cycle, AWVALID after 4; one B response consumed.
- Reset asserted during RD_DATA -> ARVALID/RREADY/REQ_DONE go to 0 immediately. After release, req1 alone is granted and completes normally.
